// File: rtl/vgarx_pkg.sv
// Shared constants and types for the TinyVGA receiver/analyser peripheral.
// Optional pixel sampler is enabled with VGARX_SAMPLE_EN (see top module).
package vgarx_pkg;

  localparam int CNT_W = 11;
  localparam int WD_W  = 12;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [WD_W-1:0]  WD_LIMIT = 12'd4095;

  localparam logic [5:0] REG_LINE_PERIOD = 6'h00;
  localparam logic [5:0] REG_HSYNC_WIDTH = 6'h04;
  localparam logic [5:0] REG_FRAME_LINES = 6'h08;
  localparam logic [5:0] REG_STATUS      = 6'h0C;
  localparam logic [5:0] REG_CTRL        = 6'h10;
  localparam logic [5:0] REG_SAMPLE_X    = 6'h14;
  localparam logic [5:0] REG_SAMPLE_Y    = 6'h18;
  localparam logic [5:0] REG_SAMPLE_DATA = 6'h1C;

  typedef enum logic [1:0] {
    ST_NO_SIGNAL = 2'd0,
    ST_ACQUIRE   = 2'd1,
    ST_LOCKED    = 2'd2
  } lock_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/vgarx_edge_det.sv
// Polarity-normalising edge detector: compares the normalised level against
// its value from the previous clock.
module vgarx_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  input  logic inv,
  output logic level,
  output logic rise,
  output logic fall
);

  logic prev_reg;

  assign level = sig ^ inv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_reg <= 1'b0;
    else        prev_reg <= level;
  end

  assign rise = level & ~prev_reg;
  assign fall = ~level & prev_reg;

endmodule

// File: rtl/tqvp_cattuto_vgarx.sv
// TinyVGA timing analyser: measures line/sync/frame geometry, tracks lock,
// raises a frame-start interrupt. Pixel sampler built only with VGARX_SAMPLE_EN.
module tqvp_cattuto_vgarx
  import vgarx_pkg::*;
#(
  parameter int CLOCK_MHZ = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);

  logic             hs_level, hs_rise, hs_fall;
  logic             vs_level, vs_rise, vs_fall;
  logic             hs_inv_reg, vs_inv_reg, irq_en_reg, irq_reg;
  logic [CNT_W-1:0] x_cnt_reg, y_cnt_reg, hw_cnt_reg;
  logic [CNT_W-1:0] line_period_reg, hsync_width_reg, frame_lines_reg;
  logic [7:0]       frame_count_reg;
  logic [WD_W-1:0]  wd_reg;
  lock_state_e      state_reg;
  logic             sample_valid;
  logic             wr_en, rd_en, lines_match;

  vgarx_edge_det u_hs_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .sig  (ui_in[7]),
    .inv  (hs_inv_reg),
    .level(hs_level),
    .rise (hs_rise),
    .fall (hs_fall)
  );

  vgarx_edge_det u_vs_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .sig  (ui_in[3]),
    .inv  (vs_inv_reg),
    .level(vs_level),
    .rise (vs_rise),
    .fall (vs_fall)
  );

  assign wr_en       = (data_write_n != 2'b11);
  assign rd_en       = (data_read_n != 2'b11);
  assign lines_match = (y_cnt_reg == frame_lines_reg) && (frame_lines_reg != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt_reg       <= '0;
      y_cnt_reg       <= '0;
      hw_cnt_reg      <= '0;
      line_period_reg <= '0;
      hsync_width_reg <= '0;
      frame_lines_reg <= '0;
      frame_count_reg <= '0;
      wd_reg          <= '0;
    end else begin
      x_cnt_reg <= hs_rise ? '0 : sat_inc(x_cnt_reg);
      if (hs_rise) line_period_reg <= sat_inc(x_cnt_reg);

      if (hs_fall) begin
        hsync_width_reg <= hw_cnt_reg;
        hw_cnt_reg      <= '0;
      end else if (hs_level) begin
        hw_cnt_reg <= sat_inc(hw_cnt_reg);
      end

      // A frame start in the same cycle as a line start restarts the line count.
      if (vs_rise) begin
        y_cnt_reg       <= '0;
        frame_lines_reg <= y_cnt_reg;
        frame_count_reg <= frame_count_reg + 8'd1;
      end else if (hs_rise) begin
        y_cnt_reg <= sat_inc(y_cnt_reg);
      end

      if (hs_rise)               wd_reg <= '0;
      else if (wd_reg != WD_LIMIT) wd_reg <= wd_reg + WD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_NO_SIGNAL;
    end else if (wd_reg == WD_LIMIT) begin
      state_reg <= ST_NO_SIGNAL;
    end else if (vs_rise) begin
      case (state_reg)
        ST_NO_SIGNAL: state_reg <= ST_ACQUIRE;
        ST_ACQUIRE:   state_reg <= lines_match ? ST_LOCKED : ST_ACQUIRE;
        ST_LOCKED:    state_reg <= lines_match ? ST_LOCKED : ST_ACQUIRE;
        default:      state_reg <= ST_NO_SIGNAL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_en_reg <= 1'b0;
      hs_inv_reg <= 1'b0;
      vs_inv_reg <= 1'b0;
      irq_reg    <= 1'b0;
    end else begin
      if (wr_en && address == REG_CTRL) begin
        irq_en_reg <= data_in[0];
        hs_inv_reg <= data_in[1];
        vs_inv_reg <= data_in[2];
      end
      if (vs_rise && irq_en_reg)             irq_reg <= 1'b1;
      else if (rd_en && address == REG_STATUS) irq_reg <= 1'b0;
    end
  end

`ifdef VGARX_SAMPLE_EN
  logic [CNT_W-1:0] sample_x_reg, sample_y_reg;
  logic [5:0]       sample_data_reg;
  logic             sample_valid_reg, sample_hit, coord_wr;
  logic [5:0]       pixel_rgb;

  assign pixel_rgb    = {ui_in[0], ui_in[4], ui_in[1], ui_in[5], ui_in[2], ui_in[6]};
  assign sample_hit   = (x_cnt_reg == sample_x_reg) && (y_cnt_reg == sample_y_reg);
  assign coord_wr     = wr_en && (address == REG_SAMPLE_X || address == REG_SAMPLE_Y);
  assign sample_valid = sample_valid_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_x_reg     <= '0;
      sample_y_reg     <= '0;
      sample_data_reg  <= '0;
      sample_valid_reg <= 1'b0;
    end else begin
      if (wr_en && address == REG_SAMPLE_X) sample_x_reg <= data_in[CNT_W-1:0];
      if (wr_en && address == REG_SAMPLE_Y) sample_y_reg <= data_in[CNT_W-1:0];
      if (sample_hit) sample_data_reg <= pixel_rgb;
      // New coordinates invalidate whatever was captured at the old ones.
      if (coord_wr)        sample_valid_reg <= 1'b0;
      else if (sample_hit) sample_valid_reg <= 1'b1;
    end
  end
`else
  assign sample_valid = 1'b0;
`endif

  always_comb begin
    data_out = '0;
    case (address)
      REG_LINE_PERIOD: data_out = {{(32-CNT_W){1'b0}}, line_period_reg};
      REG_HSYNC_WIDTH: data_out = {{(32-CNT_W){1'b0}}, hsync_width_reg};
      REG_FRAME_LINES: data_out = {{(32-CNT_W){1'b0}}, frame_lines_reg};
      REG_STATUS:      data_out = {16'b0, frame_count_reg, 5'b0, state_reg, sample_valid};
      REG_CTRL:        data_out = {29'b0, vs_inv_reg, hs_inv_reg, irq_en_reg};
`ifdef VGARX_SAMPLE_EN
      REG_SAMPLE_X:    data_out = {{(32-CNT_W){1'b0}}, sample_x_reg};
      REG_SAMPLE_Y:    data_out = {{(32-CNT_W){1'b0}}, sample_y_reg};
      REG_SAMPLE_DATA: data_out = {26'b0, sample_data_reg};
`endif
      default:         data_out = '0;
    endcase
  end

  assign uo_out         = {6'b0, state_reg == ST_LOCKED, 1'b0};
  assign data_ready     = 1'b1;
  assign user_interrupt = irq_reg;

  logic unused_inputs;
`ifdef VGARX_SAMPLE_EN
  assign unused_inputs = ^{data_in[31:CNT_W], vs_level, vs_fall, CLOCK_MHZ == 0};
`else
  assign unused_inputs = ^{data_in[31:3], ui_in[6:4], ui_in[2:0], vs_level, vs_fall,
                           CLOCK_MHZ == 0};
`endif

endmodule

// File: tb/tb_tqvp_cattuto_vgarx.sv
// Randomised bench for the TinyVGA analyser, checked against a timestamp-based
// model of the measurement rules; optional sampler follows VGARX_SAMPLE_EN.
module tb_tqvp_cattuto_vgarx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  ui_in, uo_out;
  logic [5:0]  address;
  logic [31:0] data_in, data_out;
  logic [1:0]  data_write_n, data_read_n;
  logic        data_ready, user_interrupt;

  always #50 clk = ~clk;

  tqvp_cattuto_vgarx #(.CLOCK_MHZ(64)) dut (
    .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo_out), .address(address),
    .data_in(data_in), .data_write_n(data_write_n), .data_read_n(data_read_n),
    .data_out(data_out), .data_ready(data_ready), .user_interrupt(user_interrupt)
  );

`ifdef VGARX_SAMPLE_EN
  localparam bit SAMPLE_EN = 1'b1;
`else
  localparam bit SAMPLE_EN = 1'b0;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Model: line position is "cycles since the last line start", lines are
  // "line starts since the last frame start".
  int m_cyc, m_base, m_hrun, m_lines, m_lp, m_hw, m_fl, m_fc, m_state, m_sx, m_sy, m_sdata;
  logic [2:0] m_ctrl;
  bit m_hs_prev, m_vs_prev, m_irq, m_svalid;
  logic [7:0] ui_idle;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    m_base = m_cyc; m_hrun = 0; m_lines = 0; m_lp = 0; m_hw = 0; m_fl = 0; m_fc = 0;
    m_state = 0; m_sx = 0; m_sy = 0; m_sdata = 0; m_ctrl = 3'b000;
    m_hs_prev = 0; m_vs_prev = 0; m_irq = 0; m_svalid = 0;
  endtask

  task automatic model_step(input logic [7:0] ui, input bit wr, input bit rd, input int addr,
                            input logic [31:0] wdata, output bit evt);
    bit hs, vs, hr, hf, vr, hit, lines_ok;
    int age, x, wd, rgb;
    hs = ui[7] ^ m_ctrl[1];
    vs = ui[3] ^ m_ctrl[2];
    hr = hs && !m_hs_prev;
    hf = !hs && m_hs_prev;
    vr = vs && !m_vs_prev;
    age = m_cyc - m_base;
    x = imin(age, 2047);
    wd = imin(age, 4095);
    hit = SAMPLE_EN && (x == m_sx) && (m_lines == m_sy);
    rgb = {ui[0], ui[4], ui[1], ui[5], ui[2], ui[6]};
    lines_ok = (m_lines == m_fl) && (m_fl != 0);
    if (hr) begin m_lp = imin(x + 1, 2047); m_base = m_cyc + 1; end
    if (hf) begin m_hw = m_hrun; m_hrun = 0; end
    else if (hs) m_hrun = imin(m_hrun + 1, 2047);
    if (wd == 4095) m_state = 0;
    else if (vr) m_state = (m_state == 0) ? 1 : (lines_ok ? 2 : 1);
    if (vr) begin m_fl = m_lines; m_lines = 0; m_fc = (m_fc + 1) % 256; end
    else if (hr) m_lines = imin(m_lines + 1, 2047);
    if (vr && m_ctrl[0]) m_irq = 1;
    else if (rd && addr == 12) m_irq = 0;
    if (hit) m_sdata = rgb;
    if (SAMPLE_EN && wr && (addr == 20 || addr == 24)) m_svalid = 0;
    else if (hit) m_svalid = 1;
    if (wr && addr == 16) m_ctrl = wdata[2:0];
    if (SAMPLE_EN && wr && addr == 20) m_sx = int'(wdata[10:0]);
    if (SAMPLE_EN && wr && addr == 24) m_sy = int'(wdata[10:0]);
    evt = vr || (rd && addr == 12);
    m_hs_prev = hs;
    m_vs_prev = vs;
    m_cyc++;
  endtask

  function automatic logic [31:0] model_reg(input int a);
    case (a)
      0:  return m_lp;
      4:  return m_hw;
      8:  return m_fl;
      12: return (m_fc << 8) | (m_state << 1) | int'(m_svalid);
      16: return {29'b0, m_ctrl};
      20: return m_sx;
      24: return m_sy;
      28: return m_sdata;
      default: return 0;
    endcase
  endfunction

  function automatic logic [7:0] model_uo();
    return (m_state == 2) ? 8'h02 : 8'h00;
  endfunction

  task automatic tick(input logic [7:0] ui, input bit wr, input bit rd,
                      input logic [5:0] addr, input logic [31:0] wdata);
    bit evt;
    ui_in = ui;
    address = addr;
    data_in = wdata;
    data_write_n = wr ? 2'b00 : 2'b11;
    data_read_n = rd ? 2'b00 : 2'b11;
    model_step(ui, wr, rd, int'(addr), wdata, evt);
    @(posedge clk);
    #1;
    data_write_n = 2'b11;
    data_read_n = 2'b11;
    if (evt) begin
      chk("irq", {31'b0, user_interrupt}, {31'b0, m_irq});
      chk("uo_out", {24'b0, uo_out}, {24'b0, model_uo()});
    end
  endtask

  task automatic bus_write(input logic [5:0] addr, input logic [31:0] wdata);
    tick(ui_idle, 1'b1, 1'b0, addr, wdata);
  endtask

  task automatic rd_chk(input string tag, input logic [5:0] addr);
    address = addr;
    #1;
    chk(tag, data_out, model_reg(int'(addr)));
  endtask

  task automatic dump(input string tag);
    for (int a = 0; a < 8; a++) rd_chk($sformatf("%s_r%0h", tag, a * 4), 6'(a * 4));
    chk($sformatf("%s_uo", tag), {24'b0, uo_out}, {24'b0, model_uo()});
  endtask

  task automatic gen_frames(input int len, input int hw, input int lines, input int frames,
                            input bit neg, input int vs_off, input bit rd_at_vs,
                            input int rd_rate, input bit fixed_rgb);
    logic [5:0] rgb;
    logic hs_raw, vs_raw;
    bit rd;
    for (int f = 0; f < frames; f++) begin
      for (int c = 0; c < len * lines; c++) begin
        rgb = fixed_rgb ? 6'b101101 : 6'($urandom);
        hs_raw = ((c % len) < hw) ^ neg;
        vs_raw = (c >= vs_off && c < vs_off + 2 * len) ^ neg;
        rd = (rd_at_vs && c == vs_off) ||
             (rd_rate != 0 && $urandom_range(rd_rate - 1, 0) == 0);
        tick({hs_raw, rgb[0], rgb[2], rgb[4], vs_raw, rgb[1], rgb[3], rgb[5]},
             1'b0, rd, rd ? 6'h0C : 6'h00, 32'h0);
        if (rd_at_vs && c == vs_off)
          chk("irq_rd_at_vs", {31'b0, user_interrupt}, 32'h1);
      end
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    for (int a = 0; a < 8; a++) begin
      address = 6'(a * 4);
      #1;
      chk($sformatf("rst_r%0h", a * 4), data_out, 32'h0);
    end
    chk("rst_uo", {24'b0, uo_out}, 32'h0);
    chk("rst_irq", {31'b0, user_interrupt}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int len, hw, lines;
    bit neg, irq_en;
    m_cyc = 0;
    ui_in = 8'h88; address = '0; data_in = '0;
    data_write_n = 2'b11; data_read_n = 2'b11;
    ui_idle = 8'h88;
    @(posedge clk); #3;
    apply_reset();
    chk("data_ready", {31'b0, data_ready}, 32'h1);
    $display("reset checked");

    // Negative-polarity VGA-like timing, shortened frames.
    bus_write(6'h10, 32'h7);
    gen_frames(1344, 136, 4, 3, 1'b1, 139, 1'b0, 0, 1'b0);
    address = 6'h00; #1; chk("lp_1344", data_out, 32'd1344);
    address = 6'h04; #1; chk("hw_136", data_out, 32'd136);
    address = 6'h08; #1; chk("fl_4", data_out, 32'd4);
    chk("locked_uo", {24'b0, uo_out}, 32'h2);
    chk("irq_set", {31'b0, user_interrupt}, 32'h1);
    dump("vga");
    $display("vga timing segment: lp=1344 hw=136 lines=4");

    tick(ui_idle, 1'b0, 1'b1, 6'h0C, 32'h0);
    chk("irq_clr", {31'b0, user_interrupt}, 32'h0);
    gen_frames(40, 6, 4, 2, 1'b1, 9, 1'b1, 0, 1'b0);
    dump("irq");
    $display("interrupt segment done");

    for (int i = 0; i < 4100; i++) tick(ui_idle, 1'b0, 1'b0, 6'h00, 32'h0);
    address = 6'h0C; #1; chk("wd_state", {30'b0, data_out[2:1]}, 32'h0);
    chk("wd_lock", {31'b0, uo_out[1]}, 32'h0);
    address = 6'h08; #1; chk("wd_fl", data_out, 32'd4);
    dump("wd");
    $display("watchdog segment done");

    for (int s = 0; s < 5; s++) begin
      len = $urandom_range(48, 16);
      hw = $urandom_range(len / 3, 2);
      lines = $urandom_range(8, 3);
      neg = 1'($urandom_range(1, 0));
      irq_en = 1'($urandom_range(1, 0));
      bus_write(6'h10, {29'b0, neg, neg, irq_en});
      ui_idle = neg ? 8'h88 : 8'h00;
      bus_write(6'($urandom_range(3, 0) * 4), $urandom);
      bus_write(6'h14, $urandom_range(len - 1, 0));
      bus_write(6'h18, $urandom_range(lines - 1, 0));
      gen_frames(len, hw, lines, 3, neg, hw + 3, 1'b0, 32, 1'b0);
      dump($sformatf("rnd%0d", s));
      $display("random segment %0d: len=%0d hw=%0d lines=%0d neg=%0d irq_en=%0d",
               s, len, hw, lines, neg, irq_en);
    end

    bus_write(6'h10, 32'h6);
    ui_idle = 8'h88;
    bus_write(6'h14, 32'd100);
    bus_write(6'h18, 32'd50);
    gen_frames(120, 8, 52, 1, 1'b1, 11, 1'b0, 0, 1'b1);
`ifdef VGARX_SAMPLE_EN
    address = 6'h1C; #1; chk("smp_data", data_out, 32'h2D);
    address = 6'h0C; #1; chk("smp_valid", {31'b0, data_out[0]}, 32'h1);
    bus_write(6'h14, 32'd7);
    address = 6'h0C; #1; chk("smp_valid_clr", {31'b0, data_out[0]}, 32'h0);
`else
    bus_write(6'h1C, 32'h3F);
    address = 6'h1C; #1; chk("nosmp_data", data_out, 32'h0);
    address = 6'h14; #1; chk("nosmp_x", data_out, 32'h0);
`endif
    dump("smp");
    $display("sampler segment done");

    gen_frames(3000, 100, 3, 1, 1'b1, 103, 1'b0, 0, 1'b0);
    address = 6'h00; #1; chk("lp_sat", data_out, 32'd2047);
    dump("sat");
    $display("saturation segment done");

    for (int i = 0; i < 20; i++) tick((i < 5) ? 8'h08 : 8'h88, 1'b0, 1'b0, 6'h00, 32'h0);
    #2;
    apply_reset();
    ui_idle = 8'h00;
    $display("mid-line reset checked");

    for (int p = 0; p < 260; p++) begin
      tick(8'h08, 1'b0, 1'b0, 6'h00, 32'h0);
      tick(8'h08, 1'b0, 1'b0, 6'h00, 32'h0);
      tick(8'h00, 1'b0, 1'b0, 6'h00, 32'h0);
      tick(8'h00, 1'b0, 1'b0, 6'h00, 32'h0);
    end
    address = 6'h0C; #1; chk("fc_wrap", {24'b0, data_out[15:8]}, 32'd4);
    dump("wrap");
    $display("frame count wrap segment done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/tqvp_cattuto_vgarx.md
TQVP_CATTUTO_VGARX -- requirements
Module: tqvp_cattuto_vgarx

Interface
REQ-001 SHALL have parameter CLOCK_MHZ, default 64, TinyQV clock frequency in MHz (informational; no timing derived).
REQ-002 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset; asynchronous, active-low.
REQ-004 SHALL have port ui_in  in  8  TinyVGA PMOD input {hsync, B0, G0, R0, vsync, B1, G1, R1}, pre-synchronized.
REQ-005 SHALL have port uo_out  out  8  status: bit1 = locked, all other bits 0.
REQ-006 SHALL have port address  in  6  byte address within peripheral.
REQ-007 SHALL have port data_in  in  32  write data.
REQ-008 SHALL have port data_write_n  in  2  11 = no write, else write.
REQ-009 SHALL have port data_read_n  in  2  11 = no read, else read.
REQ-010 SHALL have port data_out  out  32  combinational read data.
REQ-011 SHALL have port data_ready  out  1  tied 1; every access completes in one cycle.
REQ-012 SHALL have port user_interrupt  out  1  frame-start interrupt.

Function
REQ-013 SHALL normalize syncs: hs = ui_in[7] XOR hs_inv, vs = ui_in[3] XOR vs_inv; leading edge = registered 0 -> 1 on normalized signal.
REQ-014 x_cnt (11b) SHALL clear on hs leading edge, else increment, saturating at 2047.
REQ-015 On hs leading edge LINE_PERIOD SHALL load min(x_cnt+1, 2047).
REQ-016 hw_cnt (11b, saturating) SHALL count cycles hs is high; on hs falling edge HSYNC_WIDTH SHALL load hw_cnt, hw_cnt clears.
REQ-017 y_cnt (11b, saturating) SHALL increment on each hs leading edge and clear on vs leading edge; same-cycle vs edge: clear wins.
REQ-018 On vs leading edge FRAME_LINES SHALL load y_cnt, FRAME_COUNT (8b) SHALL increment with wrap 255 -> 0.
REQ-019 Lock FSM states NO_SIGNAL(0), ACQUIRE(1), LOCKED(2): NO_SIGNAL -> ACQUIRE on first vs edge; ACQUIRE -> LOCKED on vs edge with y_cnt == FRAME_LINES != 0; LOCKED -> ACQUIRE on vs edge with mismatch.
REQ-020 12-bit watchdog SHALL clear on hs leading edge; at 4095 FSM SHALL enter NO_SIGNAL from any state, registers retain values.
REQ-021 Register map (word offsets): 0x00 LINE_PERIOD, 0x04 HSYNC_WIDTH, 0x08 FRAME_LINES, 0x0C STATUS {FRAME_COUNT[15:8], state[2:1], sample_valid[0]}, 0x10 CTRL {vs_inv[2], hs_inv[1], irq_en[0]}, 0x14 SAMPLE_X, 0x18 SAMPLE_Y, 0x1C SAMPLE_DATA {R1,R0,G1,G0,B1,B0}; unused bits and addresses read 0.
REQ-022 Only CTRL, SAMPLE_X, SAMPLE_Y writable (low bits of data_in); other writes ignored.
REQ-023 Interrupt SHALL set on vs leading edge when irq_en=1, clear on read of STATUS; simultaneous set and clear: set wins.
REQ-024 Sampler: when x_cnt == SAMPLE_X and y_cnt == SAMPLE_Y, SAMPLE_DATA SHALL load RGB from ui_in that cycle and sample_valid SHALL set; write to SAMPLE_X or SAMPLE_Y clears sample_valid.

Reset
REQ-025 On rst_n low all counters, measurement registers, CTRL, SAMPLE_*, FRAME_COUNT, interrupt SHALL be 0, FSM NO_SIGNAL, uo_out 0, data_out per map (0); reset mid-frame discards partial counts.

Configuration
REQ-026 Macro VGARX_SAMPLE_EN defined: sampler per REQ-024; undefined: no sampler logic, 0x14/0x18/0x1C read 0, writes ignored, sample_valid reads 0.

Structure
REQ-027 Package vgarx_pkg SHALL hold register offsets, FSM state enum, counter widths (11, 12) and watchdog limit.
REQ-028 Sub-module vgarx_edge_det (registered rising/falling edge detect with inversion input) SHALL be instantiated once each for hs and vs.

Verification
REQ-029 Negative syncs, hs_inv=vs_inv=1, line 1344 clocks, hsync 136 clocks, 806 lines/frame, 3 frames -> LINE_PERIOD 1344, HSYNC_WIDTH 136, FRAME_LINES 806, state LOCKED after frame 2, uo_out[1]=1.
REQ-030 irq_en=1, vs edge -> user_interrupt 1 next cycle; STATUS read -> 0; read coincident with next vs edge -> stays 1.
REQ-031 Stop hs for 4096 clocks while LOCKED -> state NO_SIGNAL, uo_out[1]=0, FRAME_LINES unchanged.
REQ-032 SAMPLE_X=100, SAMPLE_Y=50, drive RGB 6'b101101 at that point -> SAMPLE_DATA 0x2D, sample_valid 1; write SAMPLE_X -> sample_valid 0.
REQ-033 Line period 3000 clocks -> LINE_PERIOD 2047 (saturated); 260 frames -> FRAME_COUNT wraps to 4.
REQ-034 Assert rst_n low mid-line -> all registers 0 immediately, NO_SIGNAL; without VGARX_SAMPLE_EN 0x1C reads 0 after writes.
